// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Load/store encodings, LSU state encoding and store-lane helpers
//               shared by the load/store unit and the main decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    typedef enum logic [1:0] {
        ST_SB = 2'b00,
        ST_SH = 2'b01,
        ST_SW = 2'b10
    } store_op_e;

    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101
    } load_op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } lsu_state_e;

    // Undefined encodings report as not-aligned so they never reach the bus.
    function automatic logic access_aligned(
        input logic       is_store,
        input logic [1:0] store,
        input logic [2:0] load,
        input logic [1:0] off
    );
        logic ok;
        ok = 1'b0;
        if (is_store) begin
            case (store)
                ST_SB:   ok = 1'b1;
                ST_SH:   ok = ~off[0];
                ST_SW:   ok = (off == 2'b00);
                default: ok = 1'b0;
            endcase
        end else begin
            case (load)
                LD_LB, LD_LBU: ok = 1'b1;
                LD_LH, LD_LHU: ok = ~off[0];
                LD_LW:         ok = (off == 2'b00);
                default:       ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    function automatic logic [3:0] store_strb(
        input logic [1:0] store,
        input logic [1:0] off
    );
        logic [3:0] strb;
        case (store)
            ST_SB:   strb = 4'b0001 << off;
            ST_SH:   strb = 4'b0011 << {off[1], 1'b0};
            ST_SW:   strb = 4'b1111;
            default: strb = 4'b0000;
        endcase
        return strb;
    endfunction

    function automatic logic [31:0] store_lanes(
        input logic [1:0]  store,
        input logic [31:0] data
    );
        logic [31:0] lanes;
        case (store)
            ST_SB:   lanes = {4{data[7:0]}};
            ST_SH:   lanes = {2{data[15:0]}};
            ST_SW:   lanes = data;
            default: lanes = 32'h0;
        endcase
        return lanes;
    endfunction

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
// Module      : load_extend
// Description : Selects the addressed byte/half of a read word and extends it.
// Revision    : 1.0 - initial release
// ============================================================================
module load_extend
    import riscv_pkg::*;
(
    input  logic [2:0]  load,
    input  logic [1:0]  byte_off,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    logic [7:0]  w_byte_sel;
    logic [15:0] w_half_sel;

    always_comb begin
        case (byte_off)
            2'd0:    w_byte_sel = rdata[7:0];
            2'd1:    w_byte_sel = rdata[15:8];
            2'd2:    w_byte_sel = rdata[23:16];
            default: w_byte_sel = rdata[31:24];
        endcase
        w_half_sel = byte_off[1] ? rdata[31:16] : rdata[15:0];

        case (load)
            LD_LB:   result = {{24{w_byte_sel[7]}}, w_byte_sel};
            LD_LH:   result = {{16{w_half_sel[15]}}, w_half_sel};
            LD_LW:   result = rdata;
            LD_LBU:  result = {24'h0, w_byte_sel};
            LD_LHU:  result = {16'h0, w_half_sel};
            default: result = 32'h0;
        endcase
    end

endmodule : load_extend
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Single-outstanding load/store engine between core and memory
//               bus with lane steering, misalign detection and bus timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [1:0]  Store,
    input  logic [2:0]  Load,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic        stall,
    output logic        misalign_err,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    lsu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [29:0]       word_q, word_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        load_q, load_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       ld_data_q, ld_data_d;
    logic              misalign_q, misalign_d;
    logic              bus_err_q, bus_err_d;

    logic              w_req;
    logic              w_is_store;
    logic              w_aligned;
    logic              w_in_access;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic [31:0]       w_ext_data;

    // A simultaneous read and write request is a store; the read is dropped.
    assign w_req      = MemWrite | MemRead;
    assign w_is_store = MemWrite;
    assign w_aligned  = access_aligned(w_is_store, Store, Load, addr[1:0]);
    assign w_cnt_inc  = cnt_q + 1'b1;

    load_extend u_load_extend (
        .load     (load_q),
        .byte_off (off_q),
        .rdata    (bus_rdata),
        .result   (w_ext_data)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        word_d     = word_q;
        wstrb_d    = wstrb_q;
        wdata_d    = wdata_q;
        load_d     = load_q;
        off_d      = off_q;
        ld_data_d  = ld_data_q;
        misalign_d = 1'b0;
        bus_err_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (w_req) begin
                    if (w_aligned) begin
                        we_d    = w_is_store;
                        word_d  = addr[31:2];
                        off_d   = addr[1:0];
                        load_d  = Load;
                        wstrb_d = w_is_store ? store_strb(Store, addr[1:0]) : 4'b0000;
                        wdata_d = w_is_store ? store_lanes(Store, wdata) : 32'h0;
                        state_d = S_ACCESS;
                    end else begin
                        misalign_d = 1'b1;
                        ld_data_d  = 32'h0;
                    end
                end
            end
            S_ACCESS: begin
                if (bus_ack) begin
                    if (!we_q) begin
                        ld_data_d = w_ext_data;
                    end
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else if (w_cnt_inc == CNT_W'(TIMEOUT)) begin
                    bus_err_d = 1'b1;
                    ld_data_d = 32'h0;
                    cnt_d     = '0;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = w_cnt_inc;
                end
            end
            // The requesting instruction is still presented here; it retires now.
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            word_q     <= 30'h0;
            wstrb_q    <= 4'b0000;
            wdata_q    <= 32'h0;
            load_q     <= 3'b000;
            off_q      <= 2'b00;
            ld_data_q  <= 32'h0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            word_q     <= word_d;
            wstrb_q    <= wstrb_d;
            wdata_q    <= wdata_d;
            load_q     <= load_d;
            off_q      <= off_d;
            ld_data_q  <= ld_data_d;
            misalign_q <= misalign_d;
            bus_err_q  <= bus_err_d;
        end
    end

    // Reset gates the bus immediately so an abandoned access never lingers.
    assign w_in_access  = (state_q == S_ACCESS) && !reset;

    assign bus_req      = w_in_access;
    assign bus_we       = w_in_access & we_q;
    assign bus_wstrb    = w_in_access ? wstrb_q : 4'b0000;
    assign bus_addr     = {word_q, 2'b00};
    assign bus_wdata    = wdata_q;
    assign stall        = !reset && (w_in_access ||
                          ((state_q == S_IDLE) && w_req && w_aligned));
    assign ld_data      = ld_data_q;
    assign misalign_err = misalign_q;
    assign bus_err      = bus_err_q;

endmodule : load_store_unit
`default_nettype wire
